// File: rtl/bus_arbiter_pkg.sv
// Shared bus constants for the master-side arbiter: owner codes,
// active-low enable levels and small decode helpers.
package bus_arbiter_pkg;

    localparam int BUS_OWNER_WIDTH = 2;
    localparam int NUM_MASTERS     = 4;

    typedef logic [BUS_OWNER_WIDTH-1:0] owner_t;

    localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;
    localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
    localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
    localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

    // Active-low bus levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // One-hot (active-high) select of an owner index.
    function automatic logic [NUM_MASTERS-1:0] owner_onehot(input owner_t o);
        return NUM_MASTERS'(1) << o;
    endfunction

    // Active-low grant vector for an owner: exactly one bit at ENABLE_.
    function automatic logic [NUM_MASTERS-1:0] grant_decode(input owner_t o);
        return ~owner_onehot(o);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant/owner bundle between the bus masters and the arbiter.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic   m0_req_;
    logic   m1_req_;
    logic   m2_req_;
    logic   m3_req_;
    logic   m0_grant_;
    logic   m1_grant_;
    logic   m2_grant_;
    logic   m3_grant_;
    owner_t owner;

    // Masters drive requests and observe grants/owner.
    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner
    );

    // The arbiter observes requests and drives grants/owner.
    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grant_, m1_grant_, m2_grant_, m3_grant_, owner
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin search: first active requester after the current owner
// in cyclic order owner+1, owner+2, owner+3 (and optionally the owner
// itself last). Purely combinational.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  owner_t                 owner_i,
    input  logic [NUM_MASTERS-1:0] req_i,          // active-high requests
    input  logic                   exclude_owner_i,
    output owner_t                 next_o,
    output logic                   found_o
);

    // Walk the masters cyclically from owner+1; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path
        // leaves a variable unassigned, which would infer a latch.
        next_o  = owner_i;
        found_o = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            owner_t cand;
            cand = owner_i + BUS_OWNER_WIDTH'(k);
            if (!found_o && req_i[cand] &&
                (k != NUM_MASTERS || !exclude_owner_i)) begin
                next_o  = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low request/grant,
// registered grants, bus parking on the last owner and an optional
// hold limit that forces rotation when others are waiting.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int HOLD_MAX   = 0,   // 0 = owner may hold indefinitely
    parameter int HOLD_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_LIMIT = HOLD_WIDTH'(HOLD_MAX);

    owner_t                 owner_q, owner_d;
    logic [HOLD_WIDTH-1:0]  hold_q,  hold_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   owner_req;
    logic                   others_req;
    logic                   hold_expired;
    owner_t                 pick_next;
    logic                   pick_found;

    // Active-high view of the request lines plus owner/others summaries.
    always_comb begin
        req        = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
        owner_req  = req[owner_q];
        others_req = |(req & ~owner_onehot(owner_q));
    end

    // Both release and expiry look only at the other masters, so an
    // owner dropping its request on the expiry edge rotates identically.
    bus_arb_rr_pick u_pick (
        .owner_i         (owner_q),
        .req_i           (req),
        .exclude_owner_i (1'b1),
        .next_o          (pick_next),
        .found_o         (pick_found)
    );

    // Next owner, hold count and grant decode.
    always_comb begin
        hold_expired = (HOLD_MAX != 0) && (hold_q == HOLD_LIMIT) && others_req;

        owner_d = owner_q;
        if ((!owner_req || hold_expired) && pick_found) begin
            owner_d = pick_next;
        end

        if (HOLD_MAX == 0 || owner_d != owner_q || !owner_req || !others_req) begin
            hold_d = '0;
        end else if (hold_q != HOLD_LIMIT) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = hold_q;
        end

        grant_d = grant_decode(owner_d);
    end

    // Owner, hold counter and grants; reset parks the bus on master 0.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            owner_q <= BUS_OWNER_MASTER_0;
            hold_q  <= '0;
            grant_q <= grant_decode(BUS_OWNER_MASTER_0);
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign bus.owner     = owner_q;
    assign bus.m0_grant_ = grant_q[0];
    assign bus.m1_grant_ = grant_q[1];
    assign bus.m2_grant_ = grant_q[2];
    assign bus.m3_grant_ = grant_q[3];

endmodule
